l2_mem_adapter: RTL and testbench



---
 rtl/bus_ctrl_pkg.sv | 16 +
 rtl/l2_watchdog.sv | 38 +++
 rtl/l2_mem_adapter.sv | 188 ++++++++++++++++++
 tb/tb_l2_mem_adapter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - types shared by the coherence bus controller and its L2 memory adapter
package bus_ctrl_pkg;

  localparam int BLOCK_SIZE = 2;
  localparam int DATA_WIDTH = 32 * BLOCK_SIZE;

  typedef logic [31:0] bus_word_t;

  typedef enum logic [1:0] {
    L2_FREE   = 2'b00,
    L2_BUSY   = 2'b01,
    L2_ACCESS = 2'b10,
    L2_ERROR  = 2'b11
  } l2_state_t;

endpackage

// File: rtl/l2_watchdog.sv
// rtl/l2_watchdog.sv - consecutive-busy counter; flags the TIMEOUT-th busy cycle of one word
module l2_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic nRST,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Saturates at TIMEOUT so a caller that ignores expired never sees a wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (busy && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = busy && !clear && (count_q == LAST);

endmodule

// File: rtl/l2_mem_adapter.sv
// rtl/l2_mem_adapter.sv - splits L2 block reads/writes into sequential 32-bit word accesses
module l2_mem_adapter #(
  parameter int  BLOCK_SIZE = bus_ctrl_pkg::BLOCK_SIZE,
  parameter int  TIMEOUT    = 255,
  localparam int DW         = 32 * BLOCK_SIZE
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    l2REN,
  input  logic                    l2WEN,
  input  logic [31:0]             l2addr,
  input  logic [DW-1:0]           l2store,
  output logic [DW-1:0]           l2load,
  output bus_ctrl_pkg::l2_state_t l2state,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_byte_en,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_busy,
  input  logic                    mem_error
);
  import bus_ctrl_pkg::*;

  localparam int               IDX_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [31:0]      BLK_MASK = ~32'(BLOCK_SIZE * 4 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  l2_state_t        state_q, state_d;
  logic             holdoff_q;
  logic             op_write_q, op_write_d;
  logic [31:0]      base_q, base_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  bus_word_t        wbuf_q [BLOCK_SIZE];
  bus_word_t        wbuf_d [BLOCK_SIZE];
  bus_word_t        stage_q [BLOCK_SIZE];
  bus_word_t        stage_d [BLOCK_SIZE];
  logic [DW-1:0]    load_q, load_d;
  logic             mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic             sample, start, word_done, last_word;
  logic             wd_clear, wd_busy, wd_expired;
  logic [IDX_W-1:0] nxt_idx;
  logic [31:0]      word_off;

  // The request still held through ACCESS/ERROR must not be taken as a new one.
  assign sample    = (state_q == L2_FREE) && !holdoff_q;
  assign start     = sample && (l2REN ^ l2WEN);
  assign word_done = (state_q == L2_BUSY) && !mem_busy;
  assign last_word = (idx_q == LAST_IDX);
  assign nxt_idx   = idx_q + 1'b1;
  assign word_off  = {{(30 - IDX_W){1'b0}}, nxt_idx, 2'b00};
  assign wd_clear  = (state_q != L2_BUSY) || word_done;
  assign wd_busy   = (state_q == L2_BUSY) && mem_busy;

  l2_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .nRST    (nRST),
    .clear   (wd_clear),
    .busy    (wd_busy),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= L2_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      L2_FREE: begin
        if (sample && l2REN && l2WEN) begin
          state_d = L2_ERROR;
        end else if (start) begin
          state_d = L2_BUSY;
        end
      end
      L2_BUSY: begin
        if (word_done) begin
          if (mem_error)      state_d = L2_ERROR;
          else if (last_word) state_d = L2_ACCESS;
        end else if (wd_expired) begin
          state_d = L2_ERROR;
        end
      end
      default: state_d = L2_FREE;
    endcase
  end

  always_comb begin
    op_write_d  = op_write_q;
    base_d      = base_q;
    idx_d       = idx_q;
    wbuf_d      = wbuf_q;
    stage_d     = stage_q;
    load_d      = load_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      L2_FREE: begin
        if (start) begin
          op_write_d = l2WEN;
          base_d     = l2addr & BLK_MASK;
          idx_d      = '0;
          mem_ren_d  = l2REN;
          mem_wen_d  = l2WEN;
          mem_addr_d = l2addr & BLK_MASK;
          if (l2WEN) begin
            for (int i = 0; i < BLOCK_SIZE; i++) wbuf_d[i] = l2store[32*i +: 32];
            mem_wdata_d = l2store[31:0];
          end
        end
      end
      L2_BUSY: begin
        if (word_done && !mem_error) begin
          if (!op_write_q) stage_d[idx_q] = mem_rdata;
          if (last_word) begin
            mem_ren_d = 1'b0;
            mem_wen_d = 1'b0;
            // Final word bypasses staging so the block is visible in the ACCESS cycle.
            if (!op_write_q) begin
              for (int i = 0; i < BLOCK_SIZE; i++)
                load_d[32*i +: 32] = (IDX_W'(i) == idx_q) ? mem_rdata : stage_q[i];
            end
          end else begin
            idx_d       = nxt_idx;
            mem_addr_d  = base_q | word_off;
            mem_wdata_d = wbuf_q[nxt_idx];
          end
        end else if (word_done || wd_expired) begin
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
        end
      end
      default: begin
        mem_ren_d = 1'b0;
        mem_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      holdoff_q   <= 1'b0;
      op_write_q  <= 1'b0;
      base_q      <= '0;
      idx_q       <= '0;
      load_q      <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        wbuf_q[i]  <= '0;
        stage_q[i] <= '0;
      end
    end else begin
      holdoff_q   <= (state_q == L2_ACCESS) || (state_q == L2_ERROR);
      op_write_q  <= op_write_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      load_q      <= load_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wbuf_q      <= wbuf_d;
      stage_q     <= stage_d;
    end
  end

  assign l2state     = state_q;
  assign l2load      = load_q;
  assign mem_ren     = mem_ren_q;
  assign mem_wen     = mem_wen_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_byte_en = 4'hF;

endmodule

// File: tb/tb_l2_mem_adapter.sv
// tb/tb_l2_mem_adapter.sv - directed bench with a transaction-level expected-trace model
module tb_l2_mem_adapter;
  import bus_ctrl_pkg::*;

  localparam int BS = 2;
  localparam int TO = 4;

  logic                  clk, nRST, l2REN, l2WEN;
  logic [31:0]           l2addr;
  logic [DATA_WIDTH-1:0] l2store, l2load;
  l2_state_t             l2state;
  logic                  mem_ren, mem_wen, mem_busy, mem_error;
  logic [31:0]           mem_addr, mem_wdata, mem_rdata;
  logic [3:0]            mem_byte_en;

  l2_mem_adapter #(.BLOCK_SIZE(BS), .TIMEOUT(TO)) dut (
    .clk(clk), .nRST(nRST), .l2REN(l2REN), .l2WEN(l2WEN), .l2addr(l2addr),
    .l2store(l2store), .l2load(l2load), .l2state(l2state),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_error(mem_error)
  );

  typedef struct {
    l2_state_t   st;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] load;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] done_addr[$];
  logic [31:0] done_wdata[$];
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] model_mem[logic [31:0]];
  logic [63:0] model_load;
  int          checks, errors;

  logic        stuck;
  int          busy_cnt, busy_left;
  logic [31:0] busy_addr, err_addr, cur_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory responder: settles its inputs shortly after each rising edge.
  initial begin
    cur_addr = 32'hFFFF_FFFF;
    busy_left = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ren || mem_wen) begin
        if (mem_addr != cur_addr) begin
          cur_addr  = mem_addr;
          busy_left = (mem_addr == busy_addr) ? busy_cnt : 0;
        end
        mem_busy = stuck || (busy_left > 0);
        if (busy_left > 0) busy_left--;
        mem_error = !mem_busy && (mem_addr == err_addr);
        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
        if (mem_wen && !mem_busy && !mem_error) mem_arr[mem_addr] = mem_wdata;
      end else begin
        mem_busy  = 1'b0;
        mem_error = 1'b0;
        cur_addr  = 32'hFFFF_FFFF;
      end
    end
  end

  // Compare process: one expected record per cycle while a transaction is in flight.
  always @(negedge clk) begin
    exp_t e;
    if ((mem_ren || mem_wen) && !mem_busy) begin
      done_addr.push_back(mem_addr);
      done_wdata.push_back(mem_wdata);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("l2state", 64'(l2state), 64'(e.st));
      chk("mem_ren", 64'(mem_ren), 64'(e.ren));
      chk("mem_wen", 64'(mem_wen), 64'(e.wen));
      if (e.ren || e.wen) chk("mem_addr", 64'(mem_addr), 64'(e.addr));
      if (e.wen) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
      chk("l2load", l2load, e.load);
    end
  end

  // Expected per-cycle trace from the block-transfer rules, starting at the request cycle.
  task automatic build(input bit rd, input bit wr, input logic [31:0] addr, input logic [63:0] store,
                       input int busy0, input bit stk, input int errw, output int jend);
    exp_t        r;
    logic [31:0] base;
    logic [63:0] blk;
    bit          failed;
    int          n;
    base   = addr & ~32'h7;
    blk    = model_load;
    failed = 1'b0;
    r.st = L2_FREE; r.ren = 1'b0; r.wen = 1'b0; r.addr = '0; r.wdata = '0; r.load = model_load;
    exp_q.push_back(r);
    if (rd && wr) failed = 1'b1;
    else begin
      for (int w = 0; w < BS && !failed; w++) begin
        r.st = L2_BUSY; r.ren = rd; r.wen = wr;
        r.addr  = base + 32'(4 * w);
        r.wdata = store[32*w +: 32];
        n = stk ? TO : (((w == 0) ? busy0 : 0) + 1);
        repeat (n) exp_q.push_back(r);
        if (stk || w == errw) failed = 1'b1;
        else if (rd) blk[32*w +: 32] = model_mem[r.addr];
        else model_mem[r.addr] = r.wdata;
      end
    end
    r.ren = 1'b0; r.wen = 1'b0;
    if (failed) r.st = L2_ERROR;
    else begin
      r.st = L2_ACCESS;
      if (rd) model_load = blk;
      r.load = model_load;
    end
    exp_q.push_back(r);
    jend = exp_q.size() - 1;
    r.st = L2_FREE;
    repeat (2) exp_q.push_back(r);
  endtask

  task automatic run_txn(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [63:0] store, input int busy0, input bit stk, input int errw,
                         input int extra, input int want_end, input l2_state_t want_st);
    int        jend, end_k;
    l2_state_t end_st;
    repeat (2) @(posedge clk);
    #1;
    done_addr.delete();
    done_wdata.delete();
    busy_addr = addr & ~32'h7;
    busy_cnt  = busy0;
    stuck     = stk;
    err_addr  = (errw >= 0) ? ((addr & ~32'h7) + 32'(4 * errw)) : 32'hFFFF_FFFF;
    build(rd, wr, addr, store, busy0, stk, errw, jend);
    l2REN = rd; l2WEN = wr; l2addr = addr; l2store = store;
    end_k  = -1;
    end_st = L2_FREE;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (end_k < 0 && (l2state == L2_ACCESS || l2state == L2_ERROR)) begin
        end_k  = k;
        end_st = l2state;
      end
      if (k == jend + 1 + extra) begin
        l2REN = 1'b0;
        l2WEN = 1'b0;
      end
      if (exp_q.size() == 0) break;
    end
    l2REN = 1'b0; l2WEN = 1'b0; stuck = 1'b0;
    busy_cnt = 0; err_addr = 32'hFFFF_FFFF;
    chk({tag, " end cycle"}, 64'(end_k), 64'(want_end));
    chk({tag, " end state"}, 64'(end_st), 64'(want_st));
    chk({tag, " trace drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    checks = 0; errors = 0;
    nRST = 1'b0; l2REN = 1'b0; l2WEN = 1'b0; l2addr = '0; l2store = '0;
    mem_rdata = '0; mem_busy = 1'b0; mem_error = 1'b0;
    stuck = 1'b0; busy_cnt = 0; busy_addr = 32'hFFFF_FFFF; err_addr = 32'hFFFF_FFFF;
    mem_arr[32'h1000] = 32'hAAAA0000;  model_mem[32'h1000] = 32'hAAAA0000;
    mem_arr[32'h1004] = 32'hBBBB0001;  model_mem[32'h1004] = 32'hBBBB0001;
    mem_arr[32'h4000] = 32'h12345678;  model_mem[32'h4000] = 32'h12345678;
    mem_arr[32'h4004] = 32'h9ABCDEF0;  model_mem[32'h4004] = 32'h9ABCDEF0;
    model_load = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset l2state", 64'(l2state), 64'(L2_FREE));
    chk("reset l2load", l2load, 64'h0);
    chk("reset strobes", 64'({mem_ren, mem_wen}), 64'h0);
    chk("reset mem_addr", 64'(mem_addr), 64'h0);
    chk("reset mem_wdata", 64'(mem_wdata), 64'h0);
    chk("mem_byte_en", 64'(mem_byte_en), 64'hF);
    nRST = 1'b1;

    run_txn("rd", 1, 0, 32'h1004, 64'h0, 0, 0, -1, 0, 3, L2_ACCESS);
    chk("rd l2load", l2load, 64'hBBBB0001_AAAA0000);
    chk("rd words", 64'(done_addr.size()), 64'd2);
    chk("rd addr0", 64'(done_addr[0]), 64'h1000);
    chk("rd addr1", 64'(done_addr[1]), 64'h1004);

    run_txn("wr", 0, 1, 32'h2000, 64'h22222222_11111111, 3, 0, -1, 0, 6, L2_ACCESS);
    chk("wr wdata0", 64'(done_wdata[0]), 64'h11111111);
    chk("wr wdata1", 64'(done_wdata[1]), 64'h22222222);
    chk("wr addr1", 64'(done_addr[1]), 64'h2004);
    chk("wr l2load kept", l2load, 64'hBBBB0001_AAAA0000);

    run_txn("wd", 1, 0, 32'h3000, 64'h0, 0, 1, -1, 0, 5, L2_ERROR);
    chk("wd words", 64'(done_addr.size()), 64'd0);
    chk("wd strobes", 64'({mem_ren, mem_wen}), 64'h0);

    run_txn("err", 1, 0, 32'h4000, 64'h0, 0, 0, 1, 0, 3, L2_ERROR);
    chk("err l2load kept", l2load, 64'hBBBB0001_AAAA0000);

    run_txn("both", 1, 1, 32'h5000, 64'h0, 0, 0, -1, 0, 1, L2_ERROR);
    chk("both words", 64'(done_addr.size()), 64'd0);

    run_txn("hold", 1, 0, 32'h2000, 64'h0, 0, 0, -1, 1, 3, L2_ACCESS);
    chk("hold l2load", l2load, 64'h22222222_11111111);
    chk("hold words", 64'(done_addr.size()), 64'd2);

    repeat (2) @(posedge clk);
    #1;
    stuck = 1'b1; l2REN = 1'b1; l2addr = 32'h1000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst pre state", 64'(l2state), 64'(L2_BUSY));
    nRST = 1'b0;
    #1;
    chk("rst l2state", 64'(l2state), 64'(L2_FREE));
    chk("rst strobes", 64'({mem_ren, mem_wen}), 64'h0);
    chk("rst l2load", l2load, 64'h0);
    l2REN = 1'b0; stuck = 1'b0;
    @(posedge clk);
    #1;
    nRST = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post rst state", 64'(l2state), 64'(L2_FREE));
    chk("post rst strobes", 64'({mem_ren, mem_wen}), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
